// File: rtl/acc_cpu_control_if.sv
// Memory bus between the accumulator CPU sequencer and its
// single-port synchronous memory (1-cycle read latency).
interface acc_cpu_control_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/acc_cpu_control.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Define ACC_CPU_CONTROL_STEP_EN to add single-step control on FETCH.
module acc_cpu_control #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ACC_CPU_CONTROL_STEP_EN
    input  logic          step,
`endif
    acc_cpu_control_if.master mem,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_acc,
    output logic [DW-1:0] alu_data,
    input  logic [DW-1:0] alu_z,
    input  logic          alu_cond,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic          halted
);

    typedef enum logic [2:0] {
        FETCH,
        LOAD_IR,
        DISPATCH,
        MEM_WAIT,
        EXEC,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir;
    logic [DW-1:0] mdr;
    logic [DW-1:0] acc_q;

    logic [3:0]    op;
    logic [AW-1:0] ea;
    logic          is_reg;
    logic          is_mem;
    logic          is_sta;
    logic          is_jmp;
    logic          is_ban;
    logic          is_stop;
    logic          go;

    assign op      = ir[DW-1:DW-4];
    assign ea      = ir[AW-1:0];
    assign is_reg  = (op[3:2] == 2'b00);
    assign is_mem  = (op == 4'b0101) || (op == 4'b0111);
    assign is_sta  = (op == 4'b0110);
    assign is_jmp  = (op == 4'b1000);
    assign is_ban  = (op == 4'b1001);
    assign is_stop = (op == 4'b0100);

`ifdef ACC_CPU_CONTROL_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign alu_op        = op;
    assign alu_acc       = acc_q;
    assign alu_data      = mdr;
    assign mem.mem_wdata = acc_q;
    assign pc            = pc_q;
    assign acc           = acc_q;
    assign halted        = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Strobes are purely combinational so a reset drops a pending write
    always_comb begin
        state_nx     = state;
        mem.mem_addr = pc_q;
        mem.mem_re   = 1'b0;
        mem.mem_we   = 1'b0;
        case (state)
            FETCH: begin
                mem.mem_re = 1'b1;
                if (go) begin
                    state_nx = LOAD_IR;
                end
            end
            LOAD_IR: state_nx = DISPATCH;
            DISPATCH: begin
                state_nx = FETCH;
                unique case (1'b1)
                    is_mem: begin
                        mem.mem_addr = ea;
                        mem.mem_re   = 1'b1;
                        state_nx     = MEM_WAIT;
                    end
                    is_sta: begin
                        mem.mem_addr = ea;
                        mem.mem_we   = 1'b1;
                    end
                    is_stop: state_nx = HALT;
                    default: ;
                endcase
            end
            MEM_WAIT: state_nx = EXEC;
            EXEC:     state_nx = FETCH;
            HALT:     state_nx = HALT;
            default:  state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            ir    <= '0;
            mdr   <= '0;
            acc_q <= '0;
        end else begin
            case (state)
                LOAD_IR: begin
                    ir   <= mem.mem_rdata;
                    pc_q <= pc_q + 1'b1;
                end
                DISPATCH: begin
                    if (is_reg) begin
                        acc_q <= alu_z;
                    end
                    if (is_jmp || (is_ban && alu_cond)) begin
                        pc_q <= ea;
                    end
                end
                MEM_WAIT: mdr   <= mem.mem_rdata;
                EXEC:     acc_q <= alu_z;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_control.sv
// Bench for acc_cpu_control: behavioural memory and ALU, write scoreboard,
// one task per scenario.
module tb_acc_cpu_control;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_acc;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] alu_z;
    logic          alu_cond;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          halted;

    logic [DW-1:0] mem [0:4095];
    logic [27:0]   wr_q [$];
    logic [27:0]   wr_exp;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    acc_cpu_control_if #(.AW(AW), .DW(DW)) bus ();

    acc_cpu_control #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ACC_CPU_CONTROL_STEP_EN
        .step     (1'b1),
`endif
        .mem      (bus),
        .alu_op   (alu_op),
        .alu_acc  (alu_acc),
        .alu_data (alu_data),
        .alu_z    (alu_z),
        .alu_cond (alu_cond),
        .pc       (pc),
        .acc      (acc),
        .halted   (halted)
    );

    // Reference ALU
    always_comb begin
        alu_z = alu_acc;
        case (alu_op)
            4'b0000: alu_z = '0;
            4'b0001: alu_z = ~alu_acc;
            4'b0010: alu_z = alu_acc >> 1;
            4'b0011: alu_z = {alu_acc[14:0], alu_acc[15]};
            4'b0101: alu_z = alu_acc + alu_data;
            4'b0111: alu_z = alu_data;
            default: alu_z = alu_acc;
        endcase
        alu_cond = (alu_op == 4'b1001) && alu_acc[15];
    end

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Every write strobe must match the next expected write
    always @(negedge clk) begin
        checks++;
        if (bus.mem_re && bus.mem_we) begin
            errors++;
            $display("FAIL strobe_excl: re=%b we=%b want not both",
                     bus.mem_re, bus.mem_we);
        end
        if (bus.mem_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h want none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_exp = wr_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== wr_exp) begin
                    errors++;
                    $display("FAIL write: got %h/%h want %h/%h",
                             bus.mem_addr, bus.mem_wdata,
                             wr_exp[27:16], wr_exp[15:0]);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_prog();
        rst = 1'b1;
        wr_q.delete();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hA000;
    endtask

    task automatic go();
        run(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        begin_prog();
        mem[12'h000] = 16'h7010;
        mem[12'h010] = 16'h1234;
        run(2);
        checks++;
        if (bus.mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_addr: got %h want 000", bus.mem_addr);
        end
        checks++;
        if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: re=%b we=%b want re=1 we=0",
                     bus.mem_re, bus.mem_we);
        end
        checks++;
        if (pc !== 12'h000 || acc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: pc=%h acc=%h want 000/0000", pc, acc);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted: got %b want 0", halted);
        end
    endtask

    task automatic test_load();
        rst = 1'b0;
        run(4);
        checks++;
        if (acc !== 16'h0000) begin
            errors++;
            $display("FAIL load_early: acc=%h want 0000", acc);
        end
        run(1);
        checks++;
        if (acc !== 16'h1234 || pc !== 12'h001) begin
            errors++;
            $display("FAIL load: acc=%h pc=%h want 1234/001", acc, pc);
        end
        checks++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 12'h001) begin
            errors++;
            $display("FAIL load_fetch: re=%b addr=%h want 1/001",
                     bus.mem_re, bus.mem_addr);
        end
    endtask

    task automatic test_add_wrap();
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'hFFFF;
        mem[12'h001] = 16'h5011;
        mem[12'h011] = 16'h0002;
        go();
        run(10);
        checks++;
        if (acc !== 16'h0001 || pc !== 12'h002) begin
            errors++;
            $display("FAIL add_wrap: acc=%h pc=%h want 0001/002", acc, pc);
        end
        checks++;
        if (mem[12'h011] !== 16'h0002 || mem[12'h030] !== 16'hFFFF) begin
            errors++;
            $display("FAIL add_side: m11=%h m30=%h want 0002/FFFF",
                     mem[12'h011], mem[12'h030]);
        end
    endtask

    task automatic test_reg_ops();
        logic [15:0] exp_acc [6];
        int          lat [6];
        exp_acc = '{16'h8001, 16'h7FFE, 16'h3FFF,
                    16'h7FFE, 16'h7FFE, 16'h0000};
        lat = '{5, 3, 3, 3, 3, 3};
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'h8001;
        mem[12'h001] = 16'h1000;
        mem[12'h002] = 16'h2000;
        mem[12'h003] = 16'h3000;
        mem[12'h004] = 16'hA000;
        mem[12'h005] = 16'h0000;
        go();
        for (int k = 0; k < 6; k++) begin
            run(lat[k]);
            checks++;
            if (acc !== exp_acc[k] || pc !== 12'(k + 1)) begin
                errors++;
                $display("FAIL reg_op%0d: acc=%h pc=%h want %h/%h",
                         k, acc, pc, exp_acc[k], 12'(k + 1));
            end
        end
    endtask

    task automatic test_store();
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'hBEEF;
        mem[12'h001] = 16'h6020;
        wr_q.push_back({12'h020, 16'hBEEF});
        go();
        run(7);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h020 ||
            bus.mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_bus: we=%b addr=%h data=%h want 1/020/BEEF",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        run(1);
        checks++;
        if (bus.mem_we !== 1'b0 || acc !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_after: we=%b acc=%h want 0/BEEF",
                     bus.mem_we, acc);
        end
        run(6);
        checks++;
        if (mem[12'h020] !== 16'hBEEF || wr_q.size() != 0) begin
            errors++;
            $display("FAIL store_mem: m20=%h pending=%0d want BEEF/0",
                     mem[12'h020], wr_q.size());
        end
    endtask

    task automatic test_branch();
        logic [15:0] val [2];
        logic [11:0] tgt [2];
        val = '{16'h8000, 16'h7FFF};
        tgt = '{12'h040, 12'h006};
        for (int k = 0; k < 2; k++) begin
            begin_prog();
            mem[12'h000] = 16'h7030;
            mem[12'h030] = val[k];
            mem[12'h001] = 16'h8005;
            mem[12'h005] = 16'h9040;
            go();
            run(11);
            checks++;
            if (pc !== tgt[k]) begin
                errors++;
                $display("FAIL ban%0d: pc=%h want %h", k, pc, tgt[k]);
            end
        end
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'h5555;
        mem[12'h001] = 16'h8FFF;
        mem[12'hFFF] = 16'h0000;
        go();
        run(8);
        checks++;
        if (pc !== 12'hFFF) begin
            errors++;
            $display("FAIL jmp: pc=%h want FFF", pc);
        end
        run(3);
        checks++;
        if (pc !== 12'h000 || acc !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h acc=%h want 000/0000", pc, acc);
        end
    endtask

    task automatic test_self_mod();
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'h8010;
        mem[12'h001] = 16'h6002;
        wr_q.push_back({12'h002, 16'h8010});
        go();
        run(11);
        checks++;
        if (pc !== 12'h010 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL self_mod: pc=%h pending=%0d want 010/0",
                     pc, wr_q.size());
        end
    endtask

    task automatic test_halt();
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'h1234;
        mem[12'h001] = 16'h4000;
        go();
        run(7);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_early: halted=%b want 0", halted);
        end
        run(1);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter: halted=%b want 1", halted);
        end
        for (int k = 0; k < 20; k++) begin
            run(1);
            checks++;
            if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 ||
                pc !== 12'h002 || acc !== 16'h1234 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold%0d: re=%b we=%b pc=%h acc=%h h=%b",
                         k, bus.mem_re, bus.mem_we, pc, acc, halted);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || pc !== 12'h000) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h want 0/000",
                     halted, pc);
        end
    endtask

    task automatic test_reset_mid();
        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'h1111;
        mem[12'h001] = 16'h5031;
        mem[12'h031] = 16'h2222;
        go();
        run(8);
        checks++;
        if (bus.mem_re !== 1'b0 || bus.mem_addr !== 12'h002) begin
            errors++;
            $display("FAIL mem_wait_bus: re=%b addr=%h want 0/002",
                     bus.mem_re, bus.mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (acc !== 16'h0000 || pc !== 12'h000 ||
            bus.mem_re !== 1'b1 || bus.mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL rst_add: acc=%h pc=%h re=%b addr=%h",
                     acc, pc, bus.mem_re, bus.mem_addr);
        end
        run(1);
        rst = 1'b0;
        run(10);
        checks++;
        if (acc !== 16'h3333 || pc !== 12'h002) begin
            errors++;
            $display("FAIL rerun_add: acc=%h pc=%h want 3333/002", acc, pc);
        end

        begin_prog();
        mem[12'h000] = 16'h7030;
        mem[12'h030] = 16'hBEEF;
        mem[12'h001] = 16'h6020;
        go();
        run(7);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || acc !== 16'h0000 || pc !== 12'h000) begin
            errors++;
            $display("FAIL rst_sta: we=%b acc=%h pc=%h want 0/0000/000",
                     bus.mem_we, acc, pc);
        end
        run(3);
        checks++;
        if (mem[12'h020] !== 16'hA000) begin
            errors++;
            $display("FAIL rst_sta_mem: m20=%h want A000", mem[12'h020]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_wrap();
        test_reg_ops();
        test_store();
        test_branch();
        test_self_mod();
        test_halt();
        test_reset_mid();
        run(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
